// File: rtl/lut_cfg_if.sv
// lut_cfg_if: configuration-word handshake between a word source and lut_cfg_loader.
//   cfg_data   - truth-table word to load (WIDTH bits)
//   cfg_valid  - cfg_data is valid
//   cfg_ready  - loader can accept a word
//   cfg_parity - even-parity bit for cfg_data (only with LUT_CFG_PARITY_EN defined)
// Modports: master = word source, slave = loader.
interface lut_cfg_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] cfg_data;
  logic             cfg_valid;
  logic             cfg_ready;
`ifdef LUT_CFG_PARITY_EN
  logic             cfg_parity;

  modport master (output cfg_data, output cfg_valid, output cfg_parity, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, input cfg_parity, output cfg_ready);
`else
  modport master (output cfg_data, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
`endif
endinterface

// File: rtl/lut_cfg_loader.sv
// lut_cfg_loader: serialises a WIDTH-bit truth-table word MSB first into a shift-loaded LUT.
// Optional feature macro: LUT_CFG_PARITY_EN (adds cfg_parity on the interface and the err port;
// words failing even parity are dropped and flagged with a one-cycle err pulse).
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset
//   cfg    - lut_cfg_if slave: cfg_data / cfg_valid / cfg_ready (/ cfg_parity)
//   hold   - stalls the shift while high (only meaningful while shifting)
//   lut_s  - serial bit to the LUT shift input
//   lut_en - shift enable to the LUT
//   busy   - a load is in progress
//   done   - one-cycle pulse when a load completes
//   err    - one-cycle pulse on a parity-failed word (LUT_CFG_PARITY_EN only)
module lut_cfg_loader #(
  parameter int unsigned WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  lut_cfg_if.slave  cfg,
  input  logic      hold,
  output logic      lut_s,
  output logic      lut_en,
  output logic      busy,
  output logic      done
`ifdef LUT_CFG_PARITY_EN
  ,
  output logic      err
`endif
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  sreg_q, sreg_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              cfg_ready;
  logic              accept;
  logic              load_ok;

  assign accept = (state_q == StIdle) && cfg.cfg_valid;

`ifdef LUT_CFG_PARITY_EN
  logic parity_bad;
  logic err_q;

  // Even parity over data plus parity bit must be zero for a good word.
  assign parity_bad = ^{cfg.cfg_data, cfg.cfg_parity};
  assign load_ok    = accept && !parity_bad;
  assign err        = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept && parity_bad;
    end
  end
`else
  assign load_ok = accept;
`endif

  assign cfg.cfg_ready = cfg_ready;
  assign lut_s         = sreg_q[WIDTH-1];

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    cnt_d     = cnt_q;
    cfg_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    lut_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        cfg_ready = 1'b1;
        if (load_ok) begin
          sreg_d  = cfg.cfg_data;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        busy   = 1'b1;
        lut_en = !hold;
        if (!hold) begin
          sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_lut_cfg_loader.sv
// tb_lut_cfg_loader: self-checking bench for lut_cfg_loader (WIDTH=8).
// Directed scenarios plus a randomized phase; a behavioural model tracks the load in
// progress and an attached shift-register LUT captures what the DUT actually shifts out.
// Build with LUT_CFG_PARITY_EN defined to also exercise the parity path.
module tb_lut_cfg_loader;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, hold, cfg_valid, cfg_parity;
  logic [W-1:0] cfg_data;
  logic         cfg_ready, lut_s, lut_en, busy, done;
`ifdef LUT_CFG_PARITY_EN
  logic         err;
`endif

  lut_cfg_if #(.WIDTH(W)) cfg_bus ();
  assign cfg_bus.cfg_data  = cfg_data;
  assign cfg_bus.cfg_valid = cfg_valid;
  assign cfg_ready         = cfg_bus.cfg_ready;
`ifdef LUT_CFG_PARITY_EN
  assign cfg_bus.cfg_parity = cfg_parity;
`endif

  lut_cfg_loader #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .cfg    (cfg_bus),
    .hold   (hold),
    .lut_s  (lut_s),
    .lut_en (lut_en),
    .busy   (busy),
`ifdef LUT_CFG_PARITY_EN
    .done   (done),
    .err    (err)
`else
    .done   (done)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Attached LUT and event counters, observed like real downstream logic.
  logic [W-1:0] lut_att = '0;
  int en_cnt = 0, done_cnt = 0, err_cnt = 0, cyc = 0;
  int acc_cyc[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (lut_en === 1'b1) begin
      lut_att <= {lut_att[W-2:0], lut_s};
      en_cnt  <= en_cnt + 1;
    end
    if (done === 1'b1) done_cnt <= done_cnt + 1;
`ifdef LUT_CFG_PARITY_EN
    if (err === 1'b1) err_cnt <= err_cnt + 1;
`endif
    if (!rst && cfg_ready === 1'b1 && cfg_valid) acc_cyc.push_back(cyc);
  end

  // Behavioural model: a load is "active" until all W bits have been sent, then one
  // completion cycle follows.
  bit           m_init = 0, m_active = 0, m_done = 0, m_err = 0, m_bad;
  int           m_sent = 0;
  logic [W-1:0] m_word = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1; m_active = 0; m_done = 0; m_err = 0; m_sent = 0;
    end else if (m_init) begin
      m_err = 0;
      if (m_done) begin
        m_done = 0;
      end else if (m_active) begin
        if (!hold) begin
          m_sent++;
          if (m_sent == W) begin
            m_active = 0;
            m_done   = 1;
          end
        end
      end else if (cfg_valid) begin
`ifdef LUT_CFG_PARITY_EN
        m_bad = (^cfg_data) ^ cfg_parity;
`else
        m_bad = 0;
`endif
        if (m_bad) m_err = 1;
        else begin
          m_active = 1;
          m_word   = cfg_data;
          m_sent   = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("cfg_ready", cfg_ready, !(m_active || m_done));
      chk("busy", busy, m_active || m_done);
      chk("done", done, m_done);
      chk("lut_en", lut_en, m_active && !hold);
      if (m_active) chk("lut_s", lut_s, m_word[W-1-m_sent]);
      if (m_done) chk("lut_content", lut_att, m_word);
`ifdef LUT_CFG_PARITY_EN
      chk("err", err, m_err);
`endif
    end
  end

  // Load one word; optionally hold for stall_len cycles once stall_at bits have gone out.
  // lat = cycles from the accepting edge to the cycle in which done is seen.
  task automatic do_load(input logic [W-1:0] d, input logic bad, input int stall_at,
                         input int stall_len, output int lat);
    int stalled, base;
    stalled = 0;
    base = en_cnt;
    cfg_data = d; cfg_parity = (^d) ^ bad; cfg_valid = 1;
    @(posedge clk); #1;
    cfg_valid = 0;
    lat = 1;
    while (lat < 64) begin
      if (en_cnt - base == stall_at && stalled < stall_len) begin
        hold = 1; stalled++;
      end else hold = 0;
      @(negedge clk);
      if (done === 1'b1) break;
      @(posedge clk); #1;
      lat++;
    end
    hold = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, base, d0, e0, n0;
    rst = 1; hold = 0; cfg_valid = 0; cfg_data = '0; cfg_parity = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_cfg_ready", cfg_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_lut_en", lut_en, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_lut_s", lut_s, 1'b0);
    @(posedge clk); #1;

    // Majority function, no stall.
    base = en_cnt;
    do_load(8'hE8, 1'b0, -1, 0, lat);
    chk("e8_latency", lat, 9);
    chk("e8_en_count", en_cnt - base, 8);
    chk("e8_lut", lut_att, 8'hE8);
    for (int abc = 0; abc < 8; abc++)
      chk("maj_z", lut_att[abc], (abc == 3 || abc == 5 || abc == 6 || abc == 7));

    // Stall 3 cycles after the 4th bit.
    base = en_cnt;
    do_load(8'h96, 1'b0, 4, 3, lat);
    chk("96_latency", lat, 12);
    chk("96_en_count", en_cnt - base, 8);
    chk("96_lut", lut_att, 8'h96);

    // Back-to-back with cfg_valid held high.
    n0 = acc_cyc.size();
    d0 = done_cnt;
    cfg_data = 8'hFF; cfg_parity = ^cfg_data; cfg_valid = 1;
    for (int i = 0; i < 20 && acc_cyc.size() < n0 + 1; i++) begin @(posedge clk); #1; end
    cfg_data = 8'h01; cfg_parity = ^cfg_data;
    for (int i = 0; i < 30 && acc_cyc.size() < n0 + 2; i++) begin @(posedge clk); #1; end
    cfg_valid = 0;
    for (int i = 0; i < 30 && done_cnt < d0 + 2; i++) begin @(posedge clk); #1; end
    chk("b2b_accepts", acc_cyc.size() - n0, 2);
    if (acc_cyc.size() >= n0 + 2) chk("b2b_spacing", acc_cyc[n0+1] - acc_cyc[n0], 10);
    chk("b2b_lut", lut_att, 8'h01);

    // Reset in the cycle the 5th bit of 8'hAA goes out.
    base = en_cnt;
    d0 = done_cnt;
    cfg_data = 8'hAA; cfg_parity = ^cfg_data; cfg_valid = 1;
    @(posedge clk); #1;
    cfg_valid = 0;
    for (int i = 0; i < 20 && en_cnt - base < 4; i++) begin @(posedge clk); #1; end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    repeat (12) begin @(posedge clk); #1; end
    chk("abort_en_count", en_cnt - base, 5);
    chk("abort_done_count", done_cnt - d0, 0);
    chk("abort_ready", cfg_ready, 1'b1);
    do_load(8'h0F, 1'b0, -1, 0, lat);
    chk("0f_latency", lat, 9);
    chk("0f_lut", lut_att, 8'h0F);

`ifdef LUT_CFG_PARITY_EN
    // 8'h07 has odd weight: parity 0 fails, parity 1 loads.
    e0 = err_cnt; base = en_cnt; d0 = done_cnt;
    cfg_data = 8'h07; cfg_parity = 1'b0; cfg_valid = 1;
    @(posedge clk); #1;
    cfg_valid = 0;
    repeat (4) begin @(posedge clk); #1; end
    chk("par_err_count", err_cnt - e0, 1);
    chk("par_no_en", en_cnt - base, 0);
    chk("par_no_done", done_cnt - d0, 0);
    e0 = err_cnt;
    do_load(8'h07, 1'b0, -1, 0, lat);
    chk("par_ok_latency", lat, 9);
    chk("par_ok_lut", lut_att, 8'h07);
    chk("par_ok_no_err", err_cnt - e0, 0);
`else
    e0 = 0;
`endif

    // Randomized traffic checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst        = ($urandom_range(0, 299) == 0);
      cfg_valid  = ($urandom_range(0, 2) == 0);
      cfg_data   = W'($urandom);
      cfg_parity = (^cfg_data) ^ ($urandom_range(0, 7) == 0);
      hold       = ($urandom_range(0, 3) == 0);
    end
    @(posedge clk); #1;
    rst = 0; cfg_valid = 0; hold = 0;
    repeat (15) begin @(posedge clk); #1; end
    chk("final_idle", cfg_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lut_cfg_loader.md
LUT_CFG_LOADER -- requirements
Module: lut_cfg_loader

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the LUT truth-table depth in bits (power of two, 2..64).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 The block SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 The block SHALL have port cfg_data  input  WIDTH  truth-table word to load.
REQ-006 The block SHALL have port cfg_valid  input  1  cfg_data is valid.
REQ-007 The block SHALL have port cfg_ready  output  1  the loader can accept a word.
REQ-008 The block SHALL have port hold  input  1  stalls the shift when high.
REQ-009 The block SHALL have port lut_s  output  1  serial bit to the LUT shift input.
REQ-010 The block SHALL have port lut_en  output  1  shift enable to the LUT.
REQ-011 The block SHALL have port busy  output  1  a load is in progress.
REQ-012 The block SHALL have port done  output  1  one-cycle pulse when a load completes.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-014 In IDLE: cfg_ready=1, busy=0. On a clock edge with cfg_valid=1, the block SHALL capture cfg_data into an internal shift register, clear the bit counter and enter SHIFT.
REQ-015 In SHIFT: cfg_ready=0 and busy=1; lut_s SHALL equal the shift register MSB; lut_en SHALL equal ~hold (combinational).
REQ-016 On each SHIFT edge with hold=0, the shift register SHALL shift left by one and the counter SHALL increment; on the edge where the counter reaches WIDTH-1, the FSM SHALL enter DONE.
REQ-017 With hold=0 throughout, lut_en SHALL be high for exactly WIDTH consecutive cycles, starting the cycle after acceptance. The k-th enabled bit (k=1..WIDTH) SHALL be cfg_data[WIDTH-k], so the LUT's Q[i] ends equal to cfg_data[i].
REQ-018 With hold=1 in SHIFT, the state, counter and shift register SHALL be frozen, lut_en SHALL be 0, and lut_s SHALL be stable.
REQ-019 DONE SHALL last exactly one cycle with done=1, busy=1, cfg_ready=0 and lut_en=0, then return to IDLE. Minimum spacing between acceptances is WIDTH+2 cycles.
REQ-020 cfg_valid SHALL be ignored whenever cfg_ready=0; hold SHALL be ignored outside SHIFT.
REQ-021 lut_en SHALL be 0 in every state other than SHIFT.

Reset
REQ-022 When rst=1 at an edge, the block SHALL enter IDLE, clear the counter and shift register, and set done=0. After the edge: lut_en=0, lut_s=0, busy=0, cfg_ready=1.
REQ-023 rst SHALL take priority over cfg_valid and hold.
REQ-024 A reset during SHIFT SHALL abort the load with no further lut_en pulses and no done pulse; the LUT content is then partial and the source must reissue the word.

Configuration
REQ-025 The block SHALL define the macro LUT_CFG_PARITY_EN.
REQ-026 With LUT_CFG_PARITY_EN defined, the block SHALL add port cfg_parity (input, 1 bit) and port err (output, 1 bit, reset 0). The handshake proceeds as in REQ-014. If the XOR of cfg_data and cfg_parity is 1 (even-parity failure), the block SHALL stay in IDLE, pulse err for one cycle, issue no lut_en and no done, and leave the LUT unchanged.
REQ-027 With LUT_CFG_PARITY_EN undefined, ports cfg_parity and err SHALL be absent, and every accepted word SHALL be shifted.

Verification
REQ-028 Scenario: rst=1 for 2 cycles, then 0 -> cfg_ready=1, busy=0, lut_en=0, done=0.
REQ-029 Scenario: load cfg_data=8'hE8 (majority function), hold=0 -> lut_en high 8 cycles with lut_s=1,1,1,0,1,0,0,0, then done pulse; an attached LUT gives Z=1 exactly for ABC in {011,101,110,111}.
REQ-030 Scenario: load 8'h96 with hold=1 for 3 cycles after the 4th bit -> exactly 8 enabled bits 1,0,0,1,0,1,1,0; done arrives 3 cycles later than in the unstalled case.
REQ-031 Scenario: cfg_valid held high with 8'hFF then 8'h01 -> second word accepted exactly 10 cycles after the first; the LUT holds 8'h01 at the end.
REQ-032 Scenario: rst=1 after the 5th bit of 8'hAA -> lut_en=0 from the next cycle, no done pulse; next load of 8'h0F completes normally.
REQ-033 Scenario (LUT_CFG_PARITY_EN defined): cfg_data=8'h07, cfg_parity=0 -> err pulses 1 cycle, no lut_en; with cfg_parity=1 -> normal load, err=0.
